// File: rtl/pdm_cic_decimator.sv
// 3rd-order CIC decimator: 1-bit PDM stream in, OUT_W-bit PCM samples out with a one-cycle valid.
// Optional build macro PCM_SIGNED_EN selects two's complement output centred on midscale.
module pdm_cic_decimator #(
  parameter int unsigned LOG2_DECIM = 6,
  parameter int unsigned OUT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pdm_en,
  input  logic             pdm_in,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid
);

  localparam int unsigned W     = 3 * LOG2_DECIM + 1;
  localparam int unsigned Shift = 3 * LOG2_DECIM - OUT_W;
  localparam logic [W-1:0] SatLim = {{(W-1){1'b0}}, 1'b1} << OUT_W;
  localparam logic [LOG2_DECIM-1:0] CntOne = {{(LOG2_DECIM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StComb1, StComb2, StComb3} state_e;

  state_e                state_q, state_d;
  logic [W-1:0]          i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [W-1:0]          d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [W-1:0]          c1_q, c1_d, c2_q, c2_d;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0]      pcm_q, pcm_d;
  logic                  valid_q, valid_d;

  logic                  tick;
  logic [W-1:0]          c3;
  logic [W-1:0]          c3_shift;
  logic [OUT_W-1:0]      pcm_sat;
  logic [OUT_W-1:0]      pcm_next;

  // Final comb stage and output scaling; only full scale exceeds the OUT_W range.
  assign c3       = c2_q - d3_q;
  assign c3_shift = c3 >> Shift;
  assign pcm_sat  = (c3_shift >= SatLim) ? {OUT_W{1'b1}} : c3_shift[OUT_W-1:0];

`ifdef PCM_SIGNED_EN
  assign pcm_next = {~pcm_sat[OUT_W-1], pcm_sat[OUT_W-2:0]};
`else
  assign pcm_next = pcm_sat;
`endif

  assign tick = pdm_en && (&cnt_q);

  always_comb begin
    state_d = state_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    c1_d    = c1_q;
    c2_d    = c2_q;
    cnt_d   = cnt_q;
    pcm_d   = pcm_q;
    valid_d = 1'b0;

    // Integrators run regardless of comb activity; all use pre-edge values.
    if (pdm_en) begin
      i1_d  = i1_q + {{(W-1){1'b0}}, pdm_in};
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + CntOne;
    end

    case (state_q)
      StIdle: begin
        if (tick) state_d = StComb1;
      end
      StComb1: begin
        c1_d    = i3_q - d1_q;
        d1_d    = i3_q;
        state_d = StComb2;
      end
      StComb2: begin
        c2_d    = c1_q - d2_q;
        d2_d    = c1_q;
        state_d = StComb3;
      end
      StComb3: begin
        d3_d    = c2_q;
        pcm_d   = pcm_next;
        valid_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      c1_q    <= '0;
      c2_q    <= '0;
      cnt_q   <= '0;
      pcm_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      cnt_q   <= cnt_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
    end
  end

  assign pcm_out   = pcm_q;
  assign pcm_valid = valid_q;

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Directed self-checking bench for pdm_cic_decimator at default parameters (R = 64, 16-bit out).
module tb_pdm_cic_decimator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pdm_en = 1'b0;
  logic        pdm_in = 1'b0;
  logic [15:0] pcm_out;
  logic        pcm_valid;

  int tests_run = 0;
  int tests_failed = 0;

`ifdef PCM_SIGNED_EN
  localparam logic [15:0] ExpOnes  = 16'h7FFF;
  localparam logic [15:0] ExpAlt   = 16'h0000;
  localparam logic [15:0] ExpZeros = 16'h8000;
`else
  localparam logic [15:0] ExpOnes  = 16'hFFFF;
  localparam logic [15:0] ExpAlt   = 16'h8000;
  localparam logic [15:0] ExpZeros = 16'h0000;
`endif

  int          pulse_step[$];
  logic [15:0] pulse_val[$];
  int          wide_cnt;

  pdm_cic_decimator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pdm_en    (pdm_en),
    .pdm_in    (pdm_in),
    .pcm_out   (pcm_out),
    .pcm_valid (pcm_valid)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic en, input logic din);
    pdm_en = en;
    pdm_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // pat: 0 all zeros, 1 all ones, 2 alternating starting with 1. Strobe on every en_per-th step.
  task automatic run_stream(input int n, input int en_per, input int pat);
    int   acc;
    logic prev;
    logic en;
    logic b;
    acc  = 0;
    prev = 1'b0;
    wide_cnt = 0;
    pulse_step.delete();
    pulse_val.delete();
    for (int s = 1; s <= n; s++) begin
      en = ((s % en_per) == 0);
      b  = (pat == 1) || (pat == 2 && (acc % 2) == 0);
      if (en) acc++;
      step(en, b);
      if (pcm_valid === 1'b1) begin
        if (prev) wide_cnt++;
        pulse_step.push_back(s);
        pulse_val.push_back(pcm_out);
      end
      prev = (pcm_valid === 1'b1);
    end
  endtask

  task automatic test_reset();
    bit bad;
    bad = 1'b0;
    rst_n = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step(1'b1, c[0]);
      if (pcm_valid !== 1'b0 || pcm_out !== 16'h0000) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL reset_hold: got valid=%b out=%h required valid=0 out=0000", pcm_valid, pcm_out);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    tests_run++;
    if (pcm_out !== 16'h0000 || pcm_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release: got valid=%b out=%h required valid=0 out=0000",
               pcm_valid, pcm_out);
    end
  endtask

  task automatic test_all_ones();
    int  first;
    bit  bad;
    do_reset(2);
    run_stream(394, 1, 1);
    first = (pulse_step.size() > 0) ? pulse_step[0] : -1;
    tests_run++;
    if (pulse_step.size() !== 6) begin
      tests_failed++;
      $display("FAIL ones_count: got %0d pulses required 6", pulse_step.size());
    end
    tests_run++;
    if (first !== 67) begin
      tests_failed++;
      $display("FAIL ones_first: got step %0d required 67", first);
    end
    tests_run++;
    if (wide_cnt !== 0) begin
      tests_failed++;
      $display("FAIL ones_width: got %0d wide cycles required 0", wide_cnt);
    end
    for (int k = 1; k < pulse_step.size(); k++) begin
      tests_run++;
      if (pulse_step[k] - pulse_step[k-1] !== 64) begin
        tests_failed++;
        $display("FAIL ones_period: got %0d required 64", pulse_step[k] - pulse_step[k-1]);
      end
    end
    for (int k = 3; k < pulse_val.size(); k++) begin
      tests_run++;
      if (pulse_val[k] !== ExpOnes) begin
        tests_failed++;
        $display("FAIL ones_value[%0d]: got %h required %h", k, pulse_val[k], ExpOnes);
      end
    end
    // With strobes stopped the output must hold and no pulse may appear.
    bad = 1'b0;
    repeat (300) begin
      step(1'b0, 1'b1);
      if (pcm_valid !== 1'b0 || pcm_out !== ExpOnes) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL ones_hold: got valid=%b out=%h required valid=0 out=%h",
               pcm_valid, pcm_out, ExpOnes);
    end
  endtask

  task automatic test_alternating();
    int first;
    do_reset(2);
    run_stream(394, 1, 2);
    first = (pulse_step.size() > 0) ? pulse_step[0] : -1;
    tests_run++;
    if (first !== 67 || pulse_step.size() !== 6) begin
      tests_failed++;
      $display("FAIL alt_timing: got first %0d count %0d required first 67 count 6",
               first, pulse_step.size());
    end
    for (int k = 3; k < pulse_val.size(); k++) begin
      tests_run++;
      if (pulse_val[k] !== ExpAlt) begin
        tests_failed++;
        $display("FAIL alt_value[%0d]: got %h required %h", k, pulse_val[k], ExpAlt);
      end
    end
  endtask

  task automatic test_zeros_sparse();
    int first;
    bit bad;
    do_reset(2);
    run_stream(970, 3, 0);
    first = (pulse_step.size() > 0) ? pulse_step[0] : -1;
    tests_run++;
    if (first !== 195 || pulse_step.size() !== 5) begin
      tests_failed++;
      $display("FAIL zeros_timing: got first %0d count %0d required first 195 count 5",
               first, pulse_step.size());
    end
    for (int k = 1; k < pulse_step.size(); k++) begin
      tests_run++;
      if (pulse_step[k] - pulse_step[k-1] !== 192) begin
        tests_failed++;
        $display("FAIL zeros_period: got %0d required 192", pulse_step[k] - pulse_step[k-1]);
      end
    end
    for (int k = 3; k < pulse_val.size(); k++) begin
      tests_run++;
      if (pulse_val[k] !== ExpZeros) begin
        tests_failed++;
        $display("FAIL zeros_value[%0d]: got %h required %h", k, pulse_val[k], ExpZeros);
      end
    end
    bad = 1'b0;
    repeat (1000) begin
      step(1'b0, 1'b1);
      if (pcm_valid !== 1'b0 || pcm_out !== ExpZeros) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL zeros_hold: got valid=%b out=%h required valid=0 out=%h",
               pcm_valid, pcm_out, ExpZeros);
    end
  endtask

  task automatic test_mid_reset();
    int first;
    do_reset(2);
    // One full frame (pulse at step 67) then 40 bits into the next.
    run_stream(104, 1, 1);
    tests_run++;
    if (pulse_step.size() !== 1) begin
      tests_failed++;
      $display("FAIL midrst_prefix: got %0d pulses required 1", pulse_step.size());
    end
    rst_n = 1'b0;
    step(1'b1, 1'b1);
    rst_n = 1'b1;
    tests_run++;
    if (pcm_out !== 16'h0000 || pcm_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_clear: got valid=%b out=%h required valid=0 out=0000",
               pcm_valid, pcm_out);
    end
    run_stream(200, 1, 1);
    first = (pulse_step.size() > 0) ? pulse_step[0] : -1;
    tests_run++;
    if (first !== 67) begin
      tests_failed++;
      $display("FAIL midrst_first: got step %0d required 67", first);
    end
    tests_run++;
    if (pulse_step.size() !== 3) begin
      tests_failed++;
      $display("FAIL midrst_count: got %0d pulses required 3", pulse_step.size());
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternating();
    test_zeros_sparse();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
